// File: rtl/mips_wb_pkg.sv
// Shared constants and transfer type for the register-file writeback path.
package mips_wb_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_xfer_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry buffer for load results that lost arbitration to the ALU.
// Per-slot dest/valid outputs let the writer guard same-register ordering.
module wb_skid_fifo #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic [1:0]        ent_valid,
  output logic [ADDR_W-1:0] ent_reg_0,
  output logic [ADDR_W-1:0] ent_reg_1
);
  import mips_wb_pkg::*;

  logic [ADDR_W-1:0] mem_reg  [2];
  logic [DATA_W-1:0] mem_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        valid;
  logic [1:0]        valid_next;

  // Clearing before setting lets a pop+push on the same slot (full FIFO) keep it valid.
  always_comb begin
    valid_next = valid;
    if (pop)  valid_next[rd_ptr] = 1'b0;
    if (push) valid_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      valid  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_reg[i]  <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr]  <= push_reg;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      valid <= valid_next;
      if (push && !pop && count != 2'(FIFO_DEPTH)) count <= count + 2'd1;
      else if (pop && !push && count != '0)        count <= count - 2'd1;
    end
  end

  assign head_reg  = mem_reg[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign ent_valid = valid;
  assign ent_reg_0 = mem_reg[0];
  assign ent_reg_1 = mem_reg[1];
endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: arbitrates ALU and load results into a
// single stage register, buffering colliding loads and exposing forwarding.
module writeback_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_reg,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] write_register,
  output logic              write_switch,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] fwd_read_1,
  input  logic [ADDR_W-1:0] fwd_read_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);
  import mips_wb_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        fifo_count;
  logic [1:0]        ent_valid;
  logic [ADDR_W-1:0] ent_reg_0;
  logic [ADDR_W-1:0] ent_reg_1;
  logic              guard;
  logic              alu_take;
  logic              load_take;
  logic              push;
  logic              pop;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  wb_skid_fifo #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_reg  (load_reg),
    .push_data (load_data),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_reg_0 (ent_reg_0),
    .ent_reg_1 (ent_reg_1)
  );

  // An ALU write must not overtake a buffered load to the same register.
  always_comb begin
    guard = (alu_reg != ZERO_IDX) &&
            ((ent_valid[0] && ent_reg_0 == alu_reg) ||
             (ent_valid[1] && ent_reg_1 == alu_reg));
    alu_ready  = !flush && !guard;
    load_ready = !flush && (fifo_count < 2'(FIFO_DEPTH));
    alu_take   = alu_valid && alu_ready;
    load_take  = load_valid && load_ready;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_reg   = write_register;
    sel_data  = write_data;
    push      = 1'b0;
    pop       = 1'b0;
    if (!flush) begin
      if (alu_take) begin
        sel_valid = 1'b1;
        sel_reg   = alu_reg;
        sel_data  = alu_data;
        push      = load_take;
      end else if (fifo_count != '0) begin
        sel_valid = 1'b1;
        sel_reg   = head_reg;
        sel_data  = head_data;
        pop       = 1'b1;
        push      = load_take;
      end else if (load_take) begin
        sel_valid = 1'b1;
        sel_reg   = load_reg;
        sel_data  = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_register <= '0;
      write_switch   <= 1'b0;
      write_data     <= '0;
      retired_count  <= '0;
    end else begin
      write_register <= sel_reg;
      write_data     <= sel_data;
      write_switch   <= sel_valid && (sel_reg != ZERO_IDX);
      if (sel_valid && sel_reg != ZERO_IDX && retired_count != '1)
        retired_count <= retired_count + 1'b1;
    end
  end

  assign fwd_hit_1 = write_switch && (write_register == fwd_read_1) && (fwd_read_1 != ZERO_IDX);
  assign fwd_hit_2 = write_switch && (write_register == fwd_read_2) && (fwd_read_2 != ZERO_IDX);
  assign fwd_data  = write_data;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed table plus randomized run against a queue-based reference model.
module tb_writeback_unit;
  import mips_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        load_valid, load_ready;
  logic [4:0]  load_reg;
  logic [31:0] load_data;
  logic [4:0]  write_register;
  logic        write_switch;
  logic [31:0] write_data;
  logic [4:0]  fwd_read_1, fwd_read_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_reg        (alu_reg),
    .alu_data       (alu_data),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_reg       (load_reg),
    .load_data      (load_data),
    .write_register (write_register),
    .write_switch   (write_switch),
    .write_data     (write_data),
    .fwd_read_1     (fwd_read_1),
    .fwd_read_2     (fwd_read_2),
    .fwd_hit_1      (fwd_hit_1),
    .fwd_hit_2      (fwd_hit_2),
    .fwd_data       (fwd_data),
    .retired_count  (retired_count)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        fl;
    logic        e_ar;
    logic        e_lr;
    logic        e_sw;
    logic        chk_rd;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic fl, input logic e_ar, input logic e_lr,
                              input logic e_sw, input logic chk_rd,
                              input logic [4:0] e_reg, input logic [31:0] e_data);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld; v.fl = fl;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_sw = e_sw; v.chk_rd = chk_rd;
    v.e_reg = e_reg; v.e_data = e_data;
    return v;
  endfunction

  task automatic idle_inputs();
    flush = 0; alu_valid = 0; alu_reg = 0; alu_data = 0;
    load_valid = 0; load_reg = 0; load_data = 0;
    fwd_read_1 = 0; fwd_read_2 = 0;
  endtask

  vec_t        tbl[18];
  logic [15:0] exp_ret;

  // Reference model state
  wb_xfer_t    q[$];
  logic        m_sw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [15:0] m_ret;

  initial begin
    //            av ar  ad      lv lr  ld      fl ar lr sw rd reg data
    tbl[0]  = mk(1, 2,  32'd10, 0, 0,  0,      0, 1, 1, 1, 1, 2,  32'd10);
    tbl[1]  = mk(1, 3,  32'h11, 1, 4,  32'h22, 0, 1, 1, 1, 1, 3,  32'h11);
    tbl[2]  = mk(0, 0,  0,      0, 0,  0,      0, 1, 1, 1, 1, 4,  32'h22);
    tbl[3]  = mk(1, 6,  32'h01, 1, 5,  32'h55, 0, 1, 1, 1, 1, 6,  32'h01);
    tbl[4]  = mk(1, 5,  32'h66, 0, 0,  0,      0, 0, 1, 1, 1, 5,  32'h55);
    tbl[5]  = mk(1, 5,  32'h66, 0, 0,  0,      0, 1, 1, 1, 1, 5,  32'h66);
    tbl[6]  = mk(1, 7,  32'h70, 1, 8,  32'h80, 0, 1, 1, 1, 1, 7,  32'h70);
    tbl[7]  = mk(1, 9,  32'h90, 1, 10, 32'ha0, 0, 1, 1, 1, 1, 9,  32'h90);
    tbl[8]  = mk(1, 11, 32'hb0, 1, 12, 32'hc0, 0, 1, 0, 1, 1, 11, 32'hb0);
    tbl[9]  = mk(0, 0,  0,      1, 12, 32'hc0, 0, 1, 0, 1, 1, 8,  32'h80);
    tbl[10] = mk(0, 0,  0,      1, 12, 32'hc0, 0, 1, 1, 1, 1, 10, 32'ha0);
    tbl[11] = mk(0, 0,  0,      0, 0,  0,      0, 1, 1, 1, 1, 12, 32'hc0);
    tbl[12] = mk(1, 0,  32'd20, 0, 0,  0,      0, 1, 1, 0, 1, 0,  32'd20);
    tbl[13] = mk(0, 0,  0,      0, 0,  0,      0, 1, 1, 0, 0, 0,  0);
    tbl[14] = mk(1, 13, 32'hd0, 1, 14, 32'he0, 0, 1, 1, 1, 1, 13, 32'hd0);
    tbl[15] = mk(1, 15, 32'hf0, 1, 16, 32'h100,0, 1, 1, 1, 1, 15, 32'hf0);
    tbl[16] = mk(1, 17, 32'h1,  1, 18, 32'h2,  1, 0, 0, 0, 0, 0,  0);
    tbl[17] = mk(0, 0,  0,      0, 0,  0,      0, 1, 1, 0, 0, 0,  0);

    idle_inputs();
    rst_n = 0;
    #1;
    check("rst_switch", 64'(write_switch), 0);
    check("rst_reg", 64'(write_register), 0);
    check("rst_data", 64'(write_data), 0);
    check("rst_retired", 64'(retired_count), 0);
    check("rst_alu_ready", 64'(alu_ready), 1);
    check("rst_load_ready", 64'(load_ready), 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    exp_ret = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      flush = tbl[i].fl;
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
      load_valid = tbl[i].lv; load_reg = tbl[i].lr; load_data = tbl[i].ld;
      fwd_read_1 = tbl[i].e_reg;
      fwd_read_2 = tbl[i].e_reg ^ 5'd1;
      #1;
      check($sformatf("tbl%0d_alu_ready", i), 64'(alu_ready), 64'(tbl[i].e_ar));
      check($sformatf("tbl%0d_load_ready", i), 64'(load_ready), 64'(tbl[i].e_lr));
      @(posedge clk); #1;
      if (tbl[i].e_sw) exp_ret++;
      check($sformatf("tbl%0d_switch", i), 64'(write_switch), 64'(tbl[i].e_sw));
      check($sformatf("tbl%0d_retired", i), 64'(retired_count), 64'(exp_ret));
      check($sformatf("tbl%0d_fwd_hit_1", i), 64'(fwd_hit_1),
            64'(tbl[i].e_sw && tbl[i].e_reg != 0));
      check($sformatf("tbl%0d_fwd_hit_2", i), 64'(fwd_hit_2), 0);
      if (tbl[i].chk_rd) begin
        check($sformatf("tbl%0d_reg", i), 64'(write_register), 64'(tbl[i].e_reg));
        check($sformatf("tbl%0d_data", i), 64'(write_data), 64'(tbl[i].e_data));
        check($sformatf("tbl%0d_fwd_data", i), 64'(fwd_data), 64'(tbl[i].e_data));
      end
    end

    // Reset in the middle of a transfer, with a load just buffered behind the ALU.
    @(negedge clk);
    idle_inputs();
    alu_valid = 1; alu_reg = 20; alu_data = 32'h1234;
    load_valid = 1; load_reg = 20; load_data = 32'h5678;
    fwd_read_1 = 20;
    @(posedge clk); #1;
    check("mid_switch_before", 64'(write_switch), 1);
    alu_valid = 0; load_valid = 0;
    #1 rst_n = 0;
    #1;
    check("mid_rst_switch", 64'(write_switch), 0);
    check("mid_rst_reg", 64'(write_register), 0);
    check("mid_rst_data", 64'(write_data), 0);
    check("mid_rst_retired", 64'(retired_count), 0);
    check("mid_rst_fwd_hit_1", 64'(fwd_hit_1), 0);
    check("mid_rst_load_ready", 64'(load_ready), 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_switch", 64'(write_switch), 0);

    // Randomized phase from the reset state
    q.delete();
    m_sw = 0; m_reg = 0; m_data = 0; m_ret = 0;
    for (int c = 0; c < 400; c++) begin
      logic     m_ar, m_lr, at, lt, sel;
      wb_xfer_t s;
      @(negedge clk);
      flush      = ($urandom_range(0, 24) == 0);
      alu_valid  = ($urandom_range(0, 2) != 0);
      alu_reg    = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      load_valid = ($urandom_range(0, 2) != 0);
      load_reg   = 5'($urandom_range(0, 7));
      load_data  = $urandom;
      fwd_read_1 = 5'($urandom_range(0, 7));
      fwd_read_2 = 5'($urandom_range(0, 7));
      #1;
      m_ar = !flush;
      if (alu_reg != 0)
        foreach (q[k]) if (q[k].idx == alu_reg) m_ar = 0;
      m_lr = !flush && (q.size() < 2);
      check("rnd_alu_ready", 64'(alu_ready), 64'(m_ar));
      check("rnd_load_ready", 64'(load_ready), 64'(m_lr));
      at = alu_valid && m_ar;
      lt = load_valid && m_lr;
      sel = 0;
      s = '0;
      if (flush) begin
        q.delete();
      end else if (at) begin
        s = '{idx: alu_reg, data: alu_data}; sel = 1;
        if (lt) q.push_back('{idx: load_reg, data: load_data});
      end else if (q.size() > 0) begin
        s = q.pop_front(); sel = 1;
        if (lt) q.push_back('{idx: load_reg, data: load_data});
      end else if (lt) begin
        s = '{idx: load_reg, data: load_data}; sel = 1;
      end
      if (sel) begin
        m_reg = s.idx; m_data = s.data; m_sw = (s.idx != 0);
        if (m_sw && m_ret != 16'hffff) m_ret++;
      end else begin
        m_sw = 0;
      end
      @(posedge clk); #1;
      check("rnd_switch", 64'(write_switch), 64'(m_sw));
      check("rnd_reg", 64'(write_register), 64'(m_reg));
      check("rnd_data", 64'(write_data), 64'(m_data));
      check("rnd_retired", 64'(retired_count), 64'(m_ret));
      check("rnd_fwd_hit_1", 64'(fwd_hit_1), 64'(m_sw && m_reg == fwd_read_1 && fwd_read_1 != 0));
      check("rnd_fwd_hit_2", 64'(fwd_hit_2), 64'(m_sw && m_reg == fwd_read_2 && fwd_read_2 != 0));
      check("rnd_fwd_data", 64'(fwd_data), 64'(m_data));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register file write port. Drives write_register, write_switch and write_data into register_files from the MIPS pipeline's two result sources: the ALU path and the load path.
- Arbitrates between the sources and buffers colliding load results in a 2-entry FIFO.
- Suppresses writes to $0 and exposes the in-flight write to the read side for forwarding.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 2, load-result buffer entries (fixed at 2; other values unsupported)
- CNT_W, 16, width of the retired-write counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffered and staged writes
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- load_valid  in  1  load result offered
- load_ready  out  1  load result accepted this cycle when load_valid is also high
- load_reg  in  ADDR_W  load destination register
- load_data  in  DATA_W  load result
- write_register  out  ADDR_W  register file write index
- write_switch  out  1  register file write enable
- write_data  out  DATA_W  register file write data
- fwd_read_1  in  ADDR_W  reader port 1 index, used for the forwarding compare
- fwd_read_2  in  ADDR_W  reader port 2 index, used for the forwarding compare
- fwd_hit_1  out  1  staged write matches fwd_read_1
- fwd_hit_2  out  1  staged write matches fwd_read_2
- fwd_data  out  DATA_W  staged write data (equals write_data)
- retired_count  out  CNT_W  number of committed non-$0 writes

Behaviour:
- Reset (async, rst_n=0):
  - write_register=0, write_switch=0, write_data=0, retired_count=0.
  - FIFO emptied. The ready outputs follow from the empty state: alu_ready=1, load_ready=1.
- Stage register: a single output register holds write_register, write_switch and write_data.
  - Loaded every cycle from the selected source.
  - write_switch=0 when no source is selected.
- Latency: a transfer accepted in cycle N appears at the register file port in cycle N+1, for exactly one cycle.
- Source selection priority, each cycle:
  1. ALU, if alu_valid and alu_ready.
  2. Otherwise the FIFO head, if the FIFO is non-empty.
  3. Otherwise an incoming load, if load_valid and the FIFO is empty (load bypasses the FIFO).
- Load acceptance:
  - load_ready = (fifo_count < 2). Purely combinational from the registered count.
  - An accepted load that is not selected this cycle is pushed to the FIFO tail.
  - Push and pop in the same cycle is legal; the count is unchanged.
- Ordering guard:
  - alu_ready = 0 when any valid FIFO entry has dest == alu_reg and alu_reg != 0. Otherwise alu_ready = 1.
  - This keeps same-register writes in program order while the FIFO drains.
- $0 suppression:
  - A selected transfer with dest 0 is consumed, but write_switch stays 0.
  - write_register and write_data still update.
  - retired_count does not increment.
- retired_count: increments on each cycle write_switch rises to 1 for a committed write; saturates at 2^CNT_W-1.
- Forwarding (combinational from the stage register):
  - fwd_hit_k = write_switch && (write_register == fwd_read_k) && (fwd_read_k != 0).
  - fwd_data = write_data.
- flush (synchronous):
  - Next cycle: FIFO empty, write_switch=0.
  - alu_ready and load_ready read 0 during the flush cycle; nothing is accepted.
  - retired_count is kept.
- Boundaries:
  - FIFO full plus a colliding load: load_ready=0, load not taken.
  - FIFO pointers wrap modulo 2.
  - A reset asserted mid-transfer drops everything; no partial write reaches the port after rst_n falls.

Decomposition:
- Package mips_wb_pkg holds:
  - constants DATA_W=32, ADDR_W=5, ZERO_REG=5'd0;
  - typedef wb_xfer_t {reg idx, data}.
- Sub-module wb_skid_fifo: 2-entry FIFO with push/pop/count, per-entry dest outputs for the ordering guard, and async active-low reset.

Test Plan:
- ALU only: alu_valid=1, reg=2, data=10 at cycle N -> cycle N+1 write_switch=1, write_register=2, write_data=10; retired_count=1.
- Collision: ALU (reg 3, 0x11) and load (reg 4, 0x22) in the same cycle -> N+1 writes r3=0x11, N+2 writes r4=0x22; FIFO count is 1 then 0.
- Ordering guard: load r5=0x55 buffered, ALU offers r5=0x66 -> alu_ready=0 until the load is written; then r5=0x66 is written next; final r5=0x66.
- FIFO full: three loads collide with continuous ALU writes -> load_ready drops to 0 with 2 buffered; no data lost; loads later drain in order.
- $0 write: ALU reg 0, data 20 -> write_switch stays 0; fwd_hit_1=0 with fwd_read_1=0; retired_count unchanged.
- Flush and reset: flush with 2 buffered entries -> no further writes. rst_n low mid-stream -> all outputs 0 immediately; retired_count=0.
